// File: rtl/pulse_meter.sv
// Pulse-train meter: measures delay-to-first-rise, high time and low time of a
// synchronized input, and hands one record per full period over valid/ready.
module pulse_meter #(
  parameter int CW   = 16,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sig_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] td,
  output logic [CW-1:0] th,
  output logic [CW-1:0] tl,
  output logic [CW-1:0] period,
  output logic          first,
  output logic          sat,
  output logic          overrun
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  logic [SYNC-1:0] sync_q;
  logic            s_d_q;
  logic            en_q;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            cnt_sat_q;
  logic [CW-1:0]   td_lat_q;
  logic            td_sat_q;
  logic [CW-1:0]   th_lat_q;
  logic            th_sat_q;
  logic            first_pend_q;

  logic            out_valid_q;
  logic [CW-1:0]   td_q;
  logic [CW-1:0]   th_q;
  logic [CW-1:0]   tl_q;
  logic [CW-1:0]   period_q;
  logic            first_q;
  logic            sat_q;
  logic            overrun_q;

  logic            s;
  logic            rise;
  logic            fall;
  logic [CW-1:0]   cnt_inc_d;
  logic            cnt_sat_d;
  logic [CW:0]     sum_d;
  logic            clamp_d;
  logic [CW-1:0]   period_d;
  logic            publish_d;
  logic            load_d;

  assign s    = sync_q[SYNC-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // The counter sticks at full scale; trying to step past it marks the phase saturated.
  assign cnt_inc_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign cnt_sat_d = cnt_sat_q | (cnt_q == CNT_MAX);

  assign sum_d    = {1'b0, th_lat_q} + {1'b0, cnt_q};
  assign clamp_d  = sum_d[CW];
  assign period_d = clamp_d ? CNT_MAX : sum_d[CW-1:0];

  assign publish_d = en && (state_q == LOW) && rise;
  assign load_d    = publish_d && (!out_valid_q || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      en_q         <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      cnt_sat_q    <= 1'b0;
      td_lat_q     <= '0;
      td_sat_q     <= 1'b0;
      th_lat_q     <= '0;
      th_sat_q     <= 1'b0;
      first_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      td_q         <= '0;
      th_q         <= '0;
      tl_q         <= '0;
      period_q     <= '0;
      first_q      <= 1'b0;
      sat_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], sig_in};
      s_d_q  <= s;
      en_q   <= en;

      if (en && !en_q) begin
        overrun_q <= 1'b0;
      end

      if (!en) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        cnt_sat_q    <= 1'b0;
        first_pend_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q      <= WAIT_RISE;
            cnt_q        <= '0;
            cnt_sat_q    <= 1'b0;
            td_lat_q     <= '0;
            td_sat_q     <= 1'b0;
            first_pend_q <= 1'b1;
          end
          WAIT_RISE: begin
            if (rise) begin
              td_lat_q  <= cnt_q;
              td_sat_q  <= cnt_sat_q;
              cnt_q     <= CNT_ONE;
              cnt_sat_q <= 1'b0;
              state_q   <= HIGH;
            end else begin
              cnt_q     <= cnt_inc_d;
              cnt_sat_q <= cnt_sat_d;
            end
          end
          HIGH: begin
            if (fall) begin
              th_lat_q  <= cnt_q;
              th_sat_q  <= cnt_sat_q;
              cnt_q     <= CNT_ONE;
              cnt_sat_q <= 1'b0;
              state_q   <= LOW;
            end else begin
              cnt_q     <= cnt_inc_d;
              cnt_sat_q <= cnt_sat_d;
            end
          end
          LOW: begin
            if (rise) begin
              // Delay belongs only to the first record of an enable window.
              td_lat_q     <= '0;
              td_sat_q     <= 1'b0;
              first_pend_q <= 1'b0;
              cnt_q        <= CNT_ONE;
              cnt_sat_q    <= 1'b0;
              state_q      <= HIGH;
            end else begin
              cnt_q     <= cnt_inc_d;
              cnt_sat_q <= cnt_sat_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      if (load_d) begin
        out_valid_q <= 1'b1;
        td_q        <= td_lat_q;
        th_q        <= th_lat_q;
        tl_q        <= cnt_q;
        period_q    <= period_d;
        first_q     <= first_pend_q;
        sat_q       <= td_sat_q | th_sat_q | cnt_sat_q | clamp_d;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A record arriving while the held one is still unaccepted is lost.
      if (publish_d && out_valid_q && !out_ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign td        = td_q;
  assign th        = th_q;
  assign tl        = tl_q;
  assign period    = period_q;
  assign first     = first_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed and randomized checks of pulse_meter against a phase-length model.
module tb_pulse_meter;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [15:0] td;
    logic [15:0] th;
    logic [15:0] tl;
    logic [15:0] period;
    logic        first;
    logic        sat;
  } rec_t;

  logic clk = 1'b0;
  logic rst, en, sig_in, out_ready;

  logic        a_valid, a_first, a_sat, a_overrun;
  logic [15:0] a_td, a_th, a_tl, a_period;
  logic        b_valid, b_first, b_sat, b_overrun;
  logic [3:0]  b_td, b_th, b_tl, b_period;

  int checks = 0;
  int errors = 0;

  rec_t rx_a[$];
  rec_t rx_b[$];
  rec_t exp_q[$];

  bit wv_on = 0;
  int wv_hi = 1, wv_lo = 1, wv_pos = 0;
  bit rnd_rdy = 0;

  pulse_meter #(.CW(16), .SYNC(SYNC)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .out_valid(a_valid), .out_ready(out_ready),
    .td(a_td), .th(a_th), .tl(a_tl), .period(a_period),
    .first(a_first), .sat(a_sat), .overrun(a_overrun)
  );

  pulse_meter #(.CW(4), .SYNC(SYNC)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .out_valid(b_valid), .out_ready(out_ready),
    .td(b_td), .th(b_th), .tl(b_tl), .period(b_period),
    .first(b_first), .sat(b_sat), .overrun(b_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    rec_t r;
    if (!rst && out_ready && a_valid) begin
      r.td = a_td; r.th = a_th; r.tl = a_tl; r.period = a_period;
      r.first = a_first; r.sat = a_sat;
      rx_a.push_back(r);
    end
    if (!rst && out_ready && b_valid) begin
      r.td = {12'b0, b_td}; r.th = {12'b0, b_th}; r.tl = {12'b0, b_tl};
      r.period = {12'b0, b_period}; r.first = b_first; r.sat = b_sat;
      rx_b.push_back(r);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Expected record from raw phase durations, with saturation at the field width.
  function automatic rec_t mk(int tdv, int thv, int tlv, bit fst, int cw);
    int mx, tdc, thc, tlc, sm;
    rec_t r;
    mx  = (1 << cw) - 1;
    tdc = (tdv > mx) ? mx : tdv;
    thc = (thv > mx) ? mx : thv;
    tlc = (tlv > mx) ? mx : tlv;
    sm  = thc + tlc;
    r.td     = 16'(tdc);
    r.th     = 16'(thc);
    r.tl     = 16'(tlc);
    r.period = 16'((sm > mx) ? mx : sm);
    r.first  = fst;
    r.sat    = (tdv > mx) || (thv > mx) || (tlv > mx) || (sm > mx);
    return r;
  endfunction

  function automatic rec_t cur_a();
    rec_t r;
    r.td = a_td; r.th = a_th; r.tl = a_tl; r.period = a_period;
    r.first = a_first; r.sat = a_sat;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wv_on) begin
      sig_in = (wv_pos < wv_hi);
      wv_pos = (wv_pos + 1) % (wv_hi + wv_lo);
    end
    if (rnd_rdy) begin
      if (!out_ready) out_ready = 1'b1;
      else out_ready = ($urandom % 3) != 0;
    end
  endtask

  task automatic phase(input logic v, input int n);
    sig_in = v;
    repeat (n) tick();
  endtask

  task automatic wave_start(input int hi, input int lo);
    wv_hi = hi; wv_lo = lo; wv_pos = 1 % (hi + lo);
    sig_in = 1'b1;
    wv_on = 1;
  endtask

  task automatic idle(input int n);
    en = 1'b0; wv_on = 0; rnd_rdy = 0; sig_in = 1'b0; out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic wait_valid_a(input string tag, input int limit);
    int k = 0;
    while (!a_valid && k < limit) begin
      tick();
      k++;
    end
    chk(tag, a_valid, 1'b1);
  endtask

  task automatic check_stream(input string tag, input bit use_b);
    int n;
    n = use_b ? rx_b.size() : rx_a.size();
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_rec%0d", tag, i), use_b ? rx_b[i] : rx_a[i], exp_q[i]);
  endtask

  initial begin
    rec_t r1;
    int k, h, l;

    rst = 1'b1; en = 1'b0; sig_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", a_valid, 1'b0);
    chk("reset_rec", cur_a(), mk(0, 0, 0, 0, 16));
    chk("reset_overrun", a_overrun, 1'b0);
    rst = 1'b0;

    // Basic square wave with an always-ready consumer.
    idle(4);
    rx_a.delete(); exp_q.delete();
    en = 1'b1; tick();
    phase(1'b0, 10);
    wave_start(4, 6);
    repeat (50) tick();
    idle(4);
    exp_q.push_back(mk(12, 4, 6, 1, 16));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 4, 6, 0, 16));
    check_stream("basic", 0);
    chk("basic_overrun", a_overrun, 1'b0);

    // Stalled consumer: held record stays put, later ones are dropped.
    rx_a.delete();
    out_ready = 1'b0;
    en = 1'b1; tick();
    phase(1'b0, 10);
    wave_start(4, 6);
    wait_valid_a("stall_wait_valid", 40);
    r1 = mk(12, 4, 6, 1, 16);
    chk("stall_first_rec", cur_a(), r1);
    for (int i = 0; i < 25; i++) begin
      tick();
      chk($sformatf("stall_hold%0d", i), {a_valid, cur_a()}, {1'b1, r1});
    end
    chk("stall_overrun_set", a_overrun, 1'b1);
    out_ready = 1'b1;
    repeat (30) tick();
    chk("stall_rx_enough", rx_a.size() >= 2, 1'b1);
    if (rx_a.size() >= 2) begin
      chk("stall_rx0", rx_a[0], r1);
      chk("stall_rx1", rx_a[1], mk(0, 4, 6, 0, 16));
    end
    en = 1'b0; wv_on = 0; sig_in = 1'b0;
    repeat (3) tick();
    chk("overrun_sticky", a_overrun, 1'b1);
    en = 1'b1; tick();
    chk("overrun_cleared_by_en", a_overrun, 1'b0);
    idle(4);

    // Saturation on the narrow instance; the wide one sees unclamped values.
    rx_a.delete(); rx_b.delete(); exp_q.delete();
    en = 1'b1; tick();
    phase(1'b0, 3);
    phase(1'b1, 20); phase(1'b0, 3);
    phase(1'b1, 20); phase(1'b0, 3);
    phase(1'b1, 2);  phase(1'b0, 4);
    idle(3);
    exp_q.push_back(mk(5, 20, 3, 1, 4));
    exp_q.push_back(mk(0, 20, 3, 0, 4));
    check_stream("sat_cw4", 1);
    exp_q.delete();
    exp_q.push_back(mk(5, 20, 3, 1, 16));
    exp_q.push_back(mk(0, 20, 3, 0, 16));
    check_stream("sat_cw16", 0);

    // Enable dropped mid-high: the partial period is discarded.
    rx_a.delete(); exp_q.delete();
    en = 1'b1; tick();
    phase(1'b0, 5);
    phase(1'b1, 2);
    en = 1'b0; sig_in = 1'b0;
    repeat (5) tick();
    en = 1'b1; tick();
    phase(1'b0, 7);
    phase(1'b1, 3); phase(1'b0, 5);
    phase(1'b1, 1); phase(1'b0, 4);
    idle(3);
    exp_q.push_back(mk(7 + SYNC, 3, 5, 1, 16));
    check_stream("en_drop", 0);

    // Signal already high when enabled: that level is not a rise.
    rx_a.delete(); exp_q.delete();
    sig_in = 1'b1;
    repeat (6) tick();
    en = 1'b1; tick();
    phase(1'b1, 7); phase(1'b0, 3);
    phase(1'b1, 5); phase(1'b0, 4);
    phase(1'b1, 2); phase(1'b0, 3);
    idle(3);
    exp_q.push_back(mk(7 + 3 + SYNC, 5, 4, 1, 16));
    check_stream("high_at_en", 0);

    // Random phase lengths with a jittery consumer that never stalls twice in a row.
    for (int it = 0; it < 3; it++) begin
      rx_a.delete(); exp_q.delete();
      k = $urandom_range(15, 1);
      rnd_rdy = 1;
      en = 1'b1; tick();
      phase(1'b0, k);
      for (int p = 0; p < 5; p++) begin
        h = $urandom_range(12, 2);
        l = $urandom_range(12, 2);
        phase(1'b1, h); phase(1'b0, l);
        exp_q.push_back(mk((p == 0) ? k + SYNC : 0, h, l, p == 0, 16));
      end
      phase(1'b1, 2); phase(1'b0, 4);
      idle(3);
      check_stream($sformatf("rand%0d", it), 0);
      chk($sformatf("rand%0d_overrun", it), a_overrun, 1'b0);
    end

    // Asynchronous reset while a record is held and overrun is set.
    out_ready = 1'b0;
    en = 1'b1; tick();
    phase(1'b0, 2);
    wave_start(3, 3);
    wait_valid_a("arst_wait_valid", 30);
    repeat (12) tick();
    chk("arst_pre_overrun", a_overrun, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", a_valid, 1'b0);
    chk("arst_rec", cur_a(), mk(0, 0, 0, 0, 16));
    chk("arst_overrun", a_overrun, 1'b0);
    wv_on = 0; en = 1'b0; sig_in = 1'b0;
    #1 rst = 1'b0;
    tick();
    chk("arst_after_valid", a_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
